// File: rtl/lock_sequencer.sv
// lock_sequencer
//   Entry/compare/lockout sequencer for the switch-entry combination lock.
//   One debounced enter pulse delivers one digit. The entered sequence is
//   checked against a programmable stored combination. Failed attempts are
//   counted, and reaching MAX_FAILS starts a timed lockout. The combination
//   can be re-programmed while the lock is open.
//
// Parameters
//   DIGITS          combination length (2..8)
//   MAX_FAILS       failed attempts that trigger lockout (1..7)
//   LOCKOUT_CYCLES  lockout duration in clk cycles (>= 2)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high; clears all state
//   digit_in     BCD digit on the switches
//   enter        single-cycle pulse; accepts digit_in
//   lock_req     single-cycle pulse; re-lock from OPEN, abort PROG
//   program_req  single-cycle pulse; enter PROG from OPEN
//   mode         0 ENTRY, 1 OPEN, 2 SHUT, 3 PROG, 4 LOCKOUT
//   digit_idx    index of the next digit expected
//   fail_count   consecutive failed attempts (saturates at MAX_FAILS)
//   unlocked     high only in OPEN
//   alarm        high only in LOCKOUT
//   digit_err    one-cycle pulse for an enter with digit_in > 9 (ENTRY/PROG)

module lock_sequencer #(
    parameter int DIGITS         = 6,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       enter,
    input  logic       lock_req,
    input  logic       program_req,
    output logic [2:0] mode,
    output logic [2:0] digit_idx,
    output logic [2:0] fail_count,
    output logic       unlocked,
    output logic       alarm,
    output logic       digit_err
);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_SHUT    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [2:0]    fails, fails_nxt;
    logic          miss, miss_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          err_nxt;
    logic          wr_en;
    logic          unlocked_q, alarm_q, digit_err_q;
    logic [3:0]    comb [DIGITS];

    logic          valid;
    logic          last;
    logic          digit_miss;
    logic [3:0]    fails_inc;

    // Reset combination 8,3,8,4,8,2, truncated or zero-padded to DIGITS.
    function automatic logic [3:0] default_digit(input int unsigned i);
        case (i)
            0:       return 4'd8;
            1:       return 4'd3;
            2:       return 4'd8;
            3:       return 4'd4;
            4:       return 4'd8;
            5:       return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    assign valid      = enter && (digit_in <= 4'd9);
    assign last       = (idx == 3'(DIGITS - 1));
    assign digit_miss = (digit_in != comb[idx]);
    assign fails_inc  = {1'b0, fails} + 4'd1;

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        fails_nxt    = fails;
        miss_nxt     = miss;
        lock_cnt_nxt = lock_cnt;
        err_nxt      = 1'b0;
        wr_en        = 1'b0;

        case (state)
            ST_ENTRY: begin
                if (enter && !valid) begin
                    err_nxt = 1'b1;
                end else if (valid) begin
                    if (last) begin
                        // Final digit: decide using this digit's compare
                        // together with everything accumulated so far.
                        idx_nxt  = '0;
                        miss_nxt = 1'b0;
                        if (!(miss || digit_miss)) begin
                            state_nxt = ST_OPEN;
                            fails_nxt = '0;
                        end else if (fails_inc >= 4'(MAX_FAILS)) begin
                            state_nxt    = ST_LOCKOUT;
                            fails_nxt    = 3'(MAX_FAILS);
                            lock_cnt_nxt = CW'(LOCKOUT_CYCLES);
                        end else begin
                            state_nxt = ST_SHUT;
                            fails_nxt = fails_inc[2:0];
                        end
                    end else begin
                        idx_nxt  = idx + 3'd1;
                        miss_nxt = miss || digit_miss;
                    end
                end
            end

            ST_SHUT: begin
                // The enter that leaves SHUT is not taken as a digit.
                if (enter) state_nxt = ST_ENTRY;
            end

            ST_OPEN: begin
                if (lock_req)         state_nxt = ST_ENTRY;
                else if (program_req) state_nxt = ST_PROG;
            end

            ST_PROG: begin
                // An abort wins over a digit arriving in the same cycle.
                if (lock_req) begin
                    state_nxt = ST_ENTRY;
                    idx_nxt   = '0;
                end else if (enter && !valid) begin
                    err_nxt = 1'b1;
                end else if (valid) begin
                    wr_en = 1'b1;
                    if (last) begin
                        state_nxt = ST_OPEN;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end

            ST_LOCKOUT: begin
                // Loaded with LOCKOUT_CYCLES on entry; leaving when the count
                // reads 1 gives exactly LOCKOUT_CYCLES cycles in this state.
                if (lock_cnt <= CW'(1)) begin
                    state_nxt    = ST_ENTRY;
                    fails_nxt    = '0;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt - CW'(1);
                end
            end

            default: begin
                state_nxt = ST_ENTRY;
                idx_nxt   = '0;
                miss_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_ENTRY;
            idx         <= '0;
            fails       <= '0;
            miss        <= 1'b0;
            lock_cnt    <= '0;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            digit_err_q <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                comb[i] <= default_digit(i);
            end
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            fails       <= fails_nxt;
            miss        <= miss_nxt;
            lock_cnt    <= lock_cnt_nxt;
            unlocked_q  <= (state_nxt == ST_OPEN);
            alarm_q     <= (state_nxt == ST_LOCKOUT);
            digit_err_q <= err_nxt;
            if (wr_en) comb[idx] <= digit_in;
        end
    end

    assign mode       = state;
    assign digit_idx  = idx;
    assign fail_count = fails;
    assign unlocked   = unlocked_q;
    assign alarm      = alarm_q;
    assign digit_err  = digit_err_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer
//   Self-checking bench for lock_sequencer (DIGITS=6, MAX_FAILS=3,
//   LOCKOUT_CYCLES=8). A behavioural model tracks the lock from the entered
//   digit list, the stored combination and a remaining-lockout count. All
//   outputs are compared every cycle, alongside directed scenarios with
//   literal expectations and a randomized phase.

module tb_lock_sequencer;

    localparam int D  = 6;
    localparam int MF = 3;
    localparam int LC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_in = '0;
    logic       enter = 1'b0;
    logic       lock_req = 1'b0;
    logic       program_req = 1'b0;
    logic [2:0] mode;
    logic [2:0] digit_idx;
    logic [2:0] fail_count;
    logic       unlocked;
    logic       alarm;
    logic       digit_err;

    lock_sequencer #(
        .DIGITS        (D),
        .MAX_FAILS     (MF),
        .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_in   (digit_in),
        .enter      (enter),
        .lock_req   (lock_req),
        .program_req(program_req),
        .mode       (mode),
        .digit_idx  (digit_idx),
        .fail_count (fail_count),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_mode;
    int m_fail;
    int m_err;
    int m_left;
    int m_prog_idx;
    int m_entered[$];
    int m_comb[D];
    int dflt[D] = '{8, 3, 8, 4, 8, 2};

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int d,
                              input bit l, input bit p);
        bit ok;
        m_err = 0;
        if (r) begin
            m_mode = 0; m_fail = 0; m_left = 0; m_prog_idx = 0;
            m_entered.delete();
            for (int i = 0; i < D; i++) m_comb[i] = dflt[i];
            return;
        end
        case (m_mode)
            0: if (e) begin
                if (d > 9) m_err = 1;
                else begin
                    m_entered.push_back(d);
                    if (m_entered.size() == D) begin
                        ok = 1;
                        for (int i = 0; i < D; i++)
                            if (m_entered[i] != m_comb[i]) ok = 0;
                        m_entered.delete();
                        if (ok) begin
                            m_mode = 1; m_fail = 0;
                        end else if (m_fail + 1 == MF) begin
                            m_mode = 4; m_fail = MF; m_left = LC;
                        end else begin
                            m_mode = 2; m_fail = m_fail + 1;
                        end
                    end
                end
            end
            1: begin
                if (l) m_mode = 0;
                else if (p) begin m_mode = 3; m_prog_idx = 0; end
            end
            2: if (e) m_mode = 0;
            3: begin
                if (l) begin m_mode = 0; m_prog_idx = 0; end
                else if (e) begin
                    if (d > 9) m_err = 1;
                    else begin
                        m_comb[m_prog_idx] = d;
                        m_prog_idx++;
                        if (m_prog_idx == D) begin m_mode = 1; m_prog_idx = 0; end
                    end
                end
            end
            4: begin
                m_left--;
                if (m_left == 0) begin m_mode = 0; m_fail = 0; end
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: drive at negedge, model advances at posedge, compare 1ns later.
    task automatic tick(input bit r, input bit e, input int d,
                        input bit l, input bit p);
        int exp_idx;
        reset = r; enter = e; digit_in = 4'(d); lock_req = l; program_req = p;
        @(posedge clk);
        model_step(r, e, d, l, p);
        #1;
        exp_idx = (m_mode == 0) ? m_entered.size() : (m_mode == 3) ? m_prog_idx : 0;
        chk("mode",       int'(mode),       m_mode);
        chk("digit_idx",  int'(digit_idx),  exp_idx);
        chk("fail_count", int'(fail_count), m_fail);
        chk("unlocked",   int'(unlocked),   (m_mode == 1) ? 1 : 0);
        chk("alarm",      int'(alarm),      (m_mode == 4) ? 1 : 0);
        chk("digit_err",  int'(digit_err),  m_err);
        @(negedge clk);
        reset = 0; enter = 0; lock_req = 0; program_req = 0;
    endtask

    task automatic send(input int s[D]);
        for (int i = 0; i < D; i++) tick(0, 1, s[i], 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mode"},  int'(mode), 0);
        chk({tag, "_idx"},   int'(digit_idx), 0);
        chk({tag, "_fails"}, int'(fail_count), 0);
        chk({tag, "_unl"},   int'(unlocked), 0);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_err"},   int'(digit_err), 0);
    endtask

    initial begin
        int n;
        int g;
        int d;
        @(negedge clk);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check_reset_values("reset");

        // 1: default combination opens
        send('{8, 3, 8, 4, 8, 2});
        chk("t1_mode", int'(mode), 1);
        chk("t1_unlocked", int'(unlocked), 1);
        chk("t1_fails", int'(fail_count), 0);

        // 2: mismatch only on the last digit fails
        tick(0, 0, 0, 1, 0);
        send('{8, 3, 8, 4, 8, 7});
        chk("t2_mode", int'(mode), 2);
        chk("t2_fails", int'(fail_count), 1);
        tick(0, 1, 5, 0, 0);
        chk("t2_leave_mode", int'(mode), 0);
        chk("t2_leave_idx", int'(digit_idx), 0);

        // 3: third failure locks out for exactly LC cycles
        send('{1, 1, 1, 1, 1, 1});
        chk("t3_fails2", int'(fail_count), 2);
        tick(0, 1, 0, 0, 0);
        send('{9, 9, 9, 9, 9, 9});
        chk("t3_mode_lock", int'(mode), 4);
        chk("t3_fails_sat", int'(fail_count), 3);
        n = 0; g = 0;
        while (alarm === 1'b1 && g < 50) begin
            n++; g++;
            tick(0, 1, 8, 1, 1);
        end
        chk("t3_alarm_len", n, LC);
        chk("t3_after_mode", int'(mode), 0);
        chk("t3_after_fails", int'(fail_count), 0);

        // 4: programming and re-lock
        send('{8, 3, 8, 4, 8, 2});
        tick(0, 0, 0, 0, 1);
        chk("t4_prog_mode", int'(mode), 3);
        send('{1, 2, 3, 4, 5, 6});
        chk("t4_prog_done", int'(mode), 1);
        tick(0, 0, 0, 1, 0);
        send('{8, 3, 8, 4, 8, 2});
        chk("t4_old_shut", int'(mode), 2);
        tick(0, 1, 0, 0, 0);
        send('{1, 2, 3, 4, 5, 6});
        chk("t4_new_open", int'(mode), 1);

        // 5: invalid digit pulses digit_err and is not consumed
        tick(0, 0, 0, 1, 1);
        tick(0, 1, 12, 0, 0);
        chk("t5_err", int'(digit_err), 1);
        chk("t5_idx", int'(digit_idx), 0);
        tick(0, 0, 0, 0, 0);
        chk("t5_err_drop", int'(digit_err), 0);
        send('{1, 2, 3, 4, 5, 6});
        chk("t5_open", int'(mode), 1);

        // 6a: reset mid-PROG restores the default combination
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 7, 0, 0);
        tick(0, 1, 7, 0, 0);
        tick(0, 1, 7, 0, 0);
        chk("t6_prog_idx", int'(digit_idx), 3);
        tick(1, 1, 7, 0, 0);
        check_reset_values("t6a");
        send('{8, 3, 8, 4, 8, 2});
        chk("t6a_open", int'(mode), 1);

        // 6b: reset mid-LOCKOUT cancels it
        tick(0, 0, 0, 1, 0);
        for (int k = 0; k < MF; k++) begin
            send('{0, 0, 0, 0, 0, 0});
            if (k < MF - 1) tick(0, 1, 0, 0, 0);
        end
        chk("t6b_lock", int'(alarm), 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check_reset_values("t6b");
        send('{8, 3, 8, 4, 8, 2});
        chk("t6b_open", int'(mode), 1);

        // Randomized phase, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            if (m_mode == 0 && $urandom_range(9) < 7) d = m_comb[m_entered.size()];
            else d = $urandom_range(15);
            tick($urandom_range(99) == 0,
                 $urandom_range(9) < 6, d,
                 $urandom_range(99) < 4,
                 $urandom_range(99) < 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
